// File: rtl/hdr_seq_pkg.sv
// hdr_seq_pkg: shared types and constants for the packet-header sequencer.
//   hdr_state_e  : sequencer FSM states
//   HEC_POLY     : HEC LFSR feedback taps (x^8 term implicit, polynomial 0x1A7)
//   HDR_INFO_W   : header info field width, HEC_W : HEC width
//   *_LSB/*_IDX  : bit positions of the header fields inside the 10-bit info word
package hdr_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSync,
        StTrl,
        StHdr,
        StGuard,
        StEdrs
    } hdr_state_e;

    localparam logic [7:0]  HEC_POLY   = 8'hA7;
    localparam int unsigned HDR_INFO_W = 10;
    localparam int unsigned HEC_W      = 8;
    localparam int unsigned HDR_BITS   = HDR_INFO_W + HEC_W;

    localparam int unsigned LT_ADDR_LSB = 0;
    localparam int unsigned LT_ADDR_W   = 3;
    localparam int unsigned TYPE_LSB    = 3;
    localparam int unsigned TYPE_W      = 4;
    localparam int unsigned FLOW_IDX    = 7;
    localparam int unsigned ARQN_IDX    = 8;
    localparam int unsigned SEQN_IDX    = 9;

    // One HEC LFSR step for info bit b.
    function automatic logic [HEC_W-1:0] hec_step(input logic [HEC_W-1:0] r, input logic b);
        logic fb;
        fb = r[HEC_W-1] ^ b;
        return {r[HEC_W-2:0], 1'b0} ^ (fb ? HEC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/hdr_hec_lfsr.sv
// hdr_hec_lfsr: 8-bit HEC LFSR shared by TX generation and RX checking.
//   clk_6M, rst : clock, synchronous active-high reset
//   load, seed  : load seed (has priority over step)
//   step, din   : advance one info bit
//   hec         : current LFSR contents
module hdr_hec_lfsr
    import hdr_seq_pkg::*;
(
    input  logic             clk_6M,
    input  logic             rst,
    input  logic             load,
    input  logic [HEC_W-1:0] seed,
    input  logic             step,
    input  logic             din,
    output logic [HEC_W-1:0] hec
);

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            hec <= '0;
        end else if (load) begin
            hec <= seed;
        end else if (step) begin
            hec <= hec_step(hec, din);
        end
    end

endmodule

// File: rtl/hdr_seq_p.sv
// hdr_seq_p: packet-header bit sequencer, shared TX/RX engine.
//   TX: preamble, sync word, trailer, FEC-repeated header with generated HEC.
//   RX: majority-vote header decode, HEC check, field capture.
// Inputs : clk_6M, rst (sync, active-high), p_1us bit tick, tx_start, rx_sync_hit, abort,
//          mode_id, mode_br, syncword, hec_init, tx_hdr_info, rxbit.
// Outputs: txbit, busy, hdr_en, guard_st_p, edrsync_st_p, py_st_p, pkt_done_p,
//          rx_hdr_info, rx_hdr_valid, hec_ok.
// Build option: define HDR_SEQ_HECCNT_EN to add the saturating hec_err_cnt output.
module hdr_seq_p
    import hdr_seq_pkg::*;
#(
    parameter int unsigned SYNC_BITS    = 64,
    parameter int unsigned PRE_BITS     = 4,
    parameter int unsigned TRL_BITS     = 4,
    parameter int unsigned FEC_REP      = 3,
    parameter int unsigned GUARD_BITS   = 5,
    parameter int unsigned EDRSYNC_BITS = 11
) (
    input  logic                  clk_6M,
    input  logic                  rst,
    input  logic                  p_1us,
    input  logic                  tx_start,
    input  logic                  rx_sync_hit,
    input  logic                  abort,
    input  logic                  mode_id,
    input  logic                  mode_br,
    input  logic [SYNC_BITS-1:0]  syncword,
    input  logic [HEC_W-1:0]      hec_init,
    input  logic [HDR_INFO_W-1:0] tx_hdr_info,
    input  logic                  rxbit,
    output logic                  txbit,
    output logic                  busy,
    output logic                  hdr_en,
    output logic                  guard_st_p,
    output logic                  edrsync_st_p,
    output logic                  py_st_p,
    output logic                  pkt_done_p,
    output logic [HDR_INFO_W-1:0] rx_hdr_info,
    output logic                  rx_hdr_valid,
`ifdef HDR_SEQ_HECCNT_EN
    output logic [15:0]           hec_err_cnt,
`endif
    output logic                  hec_ok
);

    localparam int unsigned HDR_TICKS = HDR_BITS * FEC_REP;
    localparam int unsigned M1 = (SYNC_BITS > HDR_TICKS) ? SYNC_BITS : HDR_TICKS;
    localparam int unsigned M2 = (PRE_BITS > TRL_BITS) ? PRE_BITS : TRL_BITS;
    localparam int unsigned M3 = (GUARD_BITS > EDRSYNC_BITS) ? GUARD_BITS : EDRSYNC_BITS;
    localparam int unsigned M12 = (M1 > M2) ? M1 : M2;
    localparam int unsigned CNT_MAX = (M12 > M3) ? M12 : M3;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);
    localparam int unsigned SIDX_W = (SYNC_BITS > 1) ? $clog2(SYNC_BITS) : 1;

    hdr_state_e            state_q;
    logic [CNT_W-1:0]      bitcnt_q;
    logic [2:0]            rep_q;
    logic [2:0]            ones_q;
    logic [4:0]            k_q;
    logic                  is_rx_q;
    logic [HDR_INFO_W-1:0] rx_sh_q;
    logic                  cmp_ok_q;
    logic                  fin_q;
    logic [HEC_W-1:0]      hec;

    logic             cnt_last, rep_last, k_info, dec_bit, info_bit, hec_bit, hdr_bit;
    logic [2:0]       ones_nx, hec_idx;
    logic [SIDX_W-1:0] sync_idx;
    logic             lfsr_load, lfsr_step, lfsr_din;

    always_comb begin
        cnt_last = 1'b0;
        case (state_q)
            StPre:   cnt_last = (bitcnt_q == CNT_W'(PRE_BITS - 1));
            StSync:  cnt_last = (bitcnt_q == CNT_W'(SYNC_BITS - 1));
            StTrl:   cnt_last = (bitcnt_q == CNT_W'(TRL_BITS - 1));
            StHdr:   cnt_last = (bitcnt_q == CNT_W'(HDR_TICKS - 1));
            StGuard: cnt_last = (bitcnt_q == CNT_W'(GUARD_BITS - 1));
            StEdrs:  cnt_last = (bitcnt_q == CNT_W'(EDRSYNC_BITS - 1));
            default: cnt_last = 1'b0;
        endcase
    end

    always_comb begin
        rep_last = (rep_q == 3'(FEC_REP - 1));
        k_info   = (k_q < 5'(HDR_INFO_W));
        ones_nx  = ones_q + {2'b00, rxbit};
        dec_bit  = (ones_nx > 3'(FEC_REP / 2));
        // HEC goes out MSB first: header bit 10 carries hec[7], bit 17 hec[0].
        hec_idx  = 3'(5'(HDR_BITS - 1) - k_q);
        hec_bit  = hec[hec_idx];
        info_bit = tx_hdr_info[k_q[3:0]];
        hdr_bit  = k_info ? info_bit : hec_bit;
        sync_idx = SIDX_W'(SYNC_BITS - 1) - SIDX_W'(bitcnt_q);
        lfsr_load = p_1us && !abort && (state_q == StTrl) && cnt_last;
        lfsr_step = p_1us && !abort && (state_q == StHdr) && rep_last && k_info;
        lfsr_din  = is_rx_q ? dec_bit : info_bit;
    end

    hdr_hec_lfsr u_hec (
        .clk_6M (clk_6M),
        .rst    (rst),
        .load   (lfsr_load),
        .seed   (hec_init),
        .step   (lfsr_step),
        .din    (lfsr_din),
        .hec    (hec)
    );

    assign busy   = (state_q != StIdle);
    assign hdr_en = (state_q == StHdr);

    always_ff @(posedge clk_6M) begin
        if (rst) begin
            state_q      <= StIdle;
            bitcnt_q     <= '0;
            rep_q        <= '0;
            ones_q       <= '0;
            k_q          <= '0;
            is_rx_q      <= 1'b0;
            rx_sh_q      <= '0;
            cmp_ok_q     <= 1'b0;
            fin_q        <= 1'b0;
            txbit        <= 1'b0;
            guard_st_p   <= 1'b0;
            edrsync_st_p <= 1'b0;
            py_st_p      <= 1'b0;
            pkt_done_p   <= 1'b0;
            rx_hdr_info  <= '0;
            rx_hdr_valid <= 1'b0;
            hec_ok       <= 1'b0;
        end else begin
            guard_st_p   <= 1'b0;
            edrsync_st_p <= 1'b0;
            py_st_p      <= 1'b0;
            pkt_done_p   <= 1'b0;
            rx_hdr_valid <= 1'b0;
            // Result of a completed RX header is published one cycle after HDR ends.
            if (fin_q) begin
                fin_q        <= 1'b0;
                rx_hdr_valid <= 1'b1;
                hec_ok       <= cmp_ok_q;
                rx_hdr_info  <= rx_sh_q;
            end
            if (abort) begin
                state_q  <= StIdle;
                bitcnt_q <= '0;
                rep_q    <= '0;
                ones_q   <= '0;
                k_q      <= '0;
                txbit    <= 1'b0;
            end else if (p_1us) begin
                bitcnt_q <= bitcnt_q + 1'b1;
                case (state_q)
                    StIdle: begin
                        txbit    <= 1'b0;
                        bitcnt_q <= '0;
                        if (tx_start) begin
                            state_q <= StPre;
                            is_rx_q <= 1'b0;
                        end else if (rx_sync_hit) begin
                            state_q <= StTrl;
                            is_rx_q <= 1'b1;
                        end
                    end
                    StPre: begin
                        txbit <= syncword[SYNC_BITS-1] ^ bitcnt_q[0];
                        if (cnt_last) begin
                            state_q  <= StSync;
                            bitcnt_q <= '0;
                        end
                    end
                    StSync: begin
                        txbit <= syncword[sync_idx];
                        if (cnt_last) begin
                            bitcnt_q <= '0;
                            if (mode_id) begin
                                pkt_done_p <= 1'b1;
                                state_q    <= StIdle;
                            end else begin
                                state_q <= StTrl;
                            end
                        end
                    end
                    StTrl: begin
                        txbit <= is_rx_q ? 1'b0 : (~syncword[0] ^ bitcnt_q[0]);
                        if (cnt_last) begin
                            state_q  <= StHdr;
                            bitcnt_q <= '0;
                            rep_q    <= '0;
                            ones_q   <= '0;
                            k_q      <= '0;
                            cmp_ok_q <= 1'b1;
                        end
                    end
                    StHdr: begin
                        txbit <= is_rx_q ? 1'b0 : hdr_bit;
                        if (rep_last) begin
                            rep_q  <= '0;
                            ones_q <= '0;
                            k_q    <= k_q + 1'b1;
                            if (is_rx_q) begin
                                if (k_info) begin
                                    rx_sh_q <= {dec_bit, rx_sh_q[HDR_INFO_W-1:1]};
                                end else if (dec_bit != hec_bit) begin
                                    cmp_ok_q <= 1'b0;
                                end
                            end
                        end else begin
                            rep_q  <= rep_q + 1'b1;
                            ones_q <= ones_nx;
                        end
                        if (cnt_last) begin
                            bitcnt_q <= '0;
                            fin_q    <= is_rx_q;
                            if (mode_br) begin
                                py_st_p    <= 1'b1;
                                pkt_done_p <= 1'b1;
                                state_q    <= StIdle;
                            end else begin
                                guard_st_p <= 1'b1;
                                state_q    <= StGuard;
                            end
                        end
                    end
                    StGuard: begin
                        txbit <= 1'b0;
                        if (cnt_last) begin
                            edrsync_st_p <= 1'b1;
                            state_q      <= StEdrs;
                            bitcnt_q     <= '0;
                        end
                    end
                    StEdrs: begin
                        txbit <= 1'b0;
                        if (cnt_last) begin
                            py_st_p    <= 1'b1;
                            pkt_done_p <= 1'b1;
                            state_q    <= StIdle;
                            bitcnt_q   <= '0;
                        end
                    end
                    default: begin
                        txbit   <= 1'b0;
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

`ifdef HDR_SEQ_HECCNT_EN
    always_ff @(posedge clk_6M) begin
        if (rst) begin
            hec_err_cnt <= '0;
        end else if (fin_q && !cmp_ok_q && (hec_err_cnt != 16'hFFFF)) begin
            hec_err_cnt <= hec_err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hdr_seq_p.sv
// tb_hdr_seq_p: self-checking bench for hdr_seq_p (default parameters).
// Expected txbit per tick and expected RX header results are queued when stimulus is
// driven and compared when the DUT produces them.
module tb_hdr_seq_p;
    import hdr_seq_pkg::*;

    logic clk_6M = 1'b0;
    always #5 clk_6M = ~clk_6M;

    logic        rst = 1'b1, p_1us = 1'b0, tx_start = 1'b0, rx_sync_hit = 1'b0, abort = 1'b0;
    logic        mode_id = 1'b0, mode_br = 1'b1, rxbit = 1'b0;
    logic [63:0] syncword = '0;
    logic [7:0]  hec_init = '0;
    logic [9:0]  tx_hdr_info = '0;
    logic        txbit, busy, hdr_en, guard_st_p, edrsync_st_p, py_st_p, pkt_done_p;
    logic [9:0]  rx_hdr_info;
    logic        rx_hdr_valid, hec_ok;
`ifdef HDR_SEQ_HECCNT_EN
    logic [15:0] hec_err_cnt;
`endif

    hdr_seq_p dut (
        .clk_6M       (clk_6M),
        .rst          (rst),
        .p_1us        (p_1us),
        .tx_start     (tx_start),
        .rx_sync_hit  (rx_sync_hit),
        .abort        (abort),
        .mode_id      (mode_id),
        .mode_br      (mode_br),
        .syncword     (syncword),
        .hec_init     (hec_init),
        .tx_hdr_info  (tx_hdr_info),
        .rxbit        (rxbit),
        .txbit        (txbit),
        .busy         (busy),
        .hdr_en       (hdr_en),
        .guard_st_p   (guard_st_p),
        .edrsync_st_p (edrsync_st_p),
        .py_st_p      (py_st_p),
        .pkt_done_p   (pkt_done_p),
        .rx_hdr_info  (rx_hdr_info),
        .rx_hdr_valid (rx_hdr_valid),
`ifdef HDR_SEQ_HECCNT_EN
        .hec_err_cnt  (hec_err_cnt),
`endif
        .hec_ok       (hec_ok)
    );

    typedef struct packed {
        logic [9:0] info;
        logic       ok;
    } rx_exp_t;

    int      n_tests = 0, n_fail = 0;
    int      cur_tick = -1;
    bit      chk_tx = 1'b0;
    bit      model_tx [0:299];
    bit      rx_samp [0:53];
    bit      exp_tx_q [$];
    rx_exp_t rx_q [$];
    int      py_cnt, py_at, pkt_cnt, pkt_at, guard_cnt, guard_at, eds_cnt, eds_at, hdr_ticks;
    int      valid_cnt = 0;
    logic    busy_post;
    logic [9:0] last_info = '0;
    logic       last_ok = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hec_ref(input logic [9:0] info, input logic [7:0] seed);
        logic [7:0] r;
        logic       fb;
        r = seed;
        for (int i = 0; i < 10; i++) begin
            fb = r[7] ^ info[i];
            r  = {r[6:0], 1'b0};
            if (fb) r = r ^ 8'hA7;
        end
        return r;
    endfunction

    // Expected txbit after each tick; tick 0 is the tx_start tick.
    task automatic build_tx(input logic [63:0] sw, input logic [9:0] info, input logic [7:0] seed,
                            input bit id);
        logic [7:0] h;
        int         j;
        h = hec_ref(info, seed);
        for (int t = 0; t < 300; t++) begin
            model_tx[t] = 1'b0;
            if (t >= 1 && t <= 4) model_tx[t] = sw[63] ^ ((t - 1) % 2 != 0);
            else if (t >= 5 && t <= 68) model_tx[t] = sw[68-t];
            else if (!id && t >= 69 && t <= 72) model_tx[t] = ~sw[0] ^ ((t - 69) % 2 != 0);
            else if (!id && t >= 73 && t <= 126) begin
                j = (t - 73) / 3;
                model_tx[t] = (j < 10) ? info[j] : h[17-j];
            end
        end
    endtask

    task automatic clr_mon();
        py_cnt = 0; py_at = -1; pkt_cnt = 0; pkt_at = -1;
        guard_cnt = 0; guard_at = -1; eds_cnt = 0; eds_at = -1; hdr_ticks = 0;
        cur_tick = -1;
    endtask

    task automatic tick(input logic rb);
        cur_tick++;
        rxbit = rb;
        p_1us = 1'b1;
        if (chk_tx) exp_tx_q.push_back(model_tx[cur_tick]);
        @(posedge clk_6M);
        #1;
        p_1us = 1'b0; tx_start = 1'b0; rx_sync_hit = 1'b0; abort = 1'b0;
        busy_post = busy;
        if (hdr_en) hdr_ticks++;
        if (chk_tx) check_eq($sformatf("txbit@%0d", cur_tick), 32'(txbit), 32'(exp_tx_q.pop_front()));
        repeat (5) @(posedge clk_6M);
        #1;
    endtask

    always @(negedge clk_6M) begin
        if (py_st_p) begin py_cnt++; py_at = cur_tick; end
        if (pkt_done_p) begin pkt_cnt++; pkt_at = cur_tick; end
        if (guard_st_p) begin guard_cnt++; guard_at = cur_tick; end
        if (edrsync_st_p) begin eds_cnt++; eds_at = cur_tick; end
        if (rx_hdr_valid) begin
            rx_exp_t e;
            valid_cnt++;
            if (rx_q.size() == 0) begin
                check_eq("rx_valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = rx_q.pop_front();
                check_eq("rx_hdr_info", 32'(rx_hdr_info), 32'(e.info));
                check_eq("hec_ok", 32'(hec_ok), 32'(e.ok));
            end
        end
    end

    task automatic run_tx(input logic [63:0] sw, input logic [9:0] info, input logic [7:0] seed,
                          input bit br, input bit id, input int n_ticks,
                          input int exp_py, input int exp_guard, input int exp_eds);
        syncword = sw; tx_hdr_info = info; hec_init = seed; mode_br = br; mode_id = id;
        build_tx(sw, info, seed, id);
        clr_mon();
        chk_tx = 1'b1;
        tx_start = 1'b1;
        tick(1'b0);
        for (int i = 1; i <= n_ticks; i++) begin
            // Starts while busy must be ignored.
            if (i == 30) begin tx_start = 1'b1; rx_sync_hit = 1'b1; end
            tick(1'($urandom_range(0, 1)));
        end
        chk_tx = 1'b0;
        check_eq("tx_busy_end", 32'(busy), 32'd0);
        check_eq("tx_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check_eq("tx_pkt_at", 32'(pkt_at), 32'(exp_py));
        if (id) begin
            check_eq("id_py_cnt", 32'(py_cnt), 32'd0);
            check_eq("id_hdr_ticks", 32'(hdr_ticks), 32'd0);
        end else begin
            check_eq("tx_py_at", 32'(py_at), 32'(exp_py));
            check_eq("tx_hdr_ticks", 32'(hdr_ticks), 32'd54);
            check_eq("tx_guard_cnt", 32'(guard_cnt), br ? 32'd0 : 32'd1);
            if (!br) begin
                check_eq("tx_guard_at", 32'(guard_at), 32'(exp_guard));
                check_eq("tx_edrsync_at", 32'(eds_at), 32'(exp_eds));
            end
        end
    endtask

    // flip: 0 clean, 1 one sample of every triple, 2 two samples of header bit 3.
    task automatic run_rx(input logic [9:0] info, input logic [7:0] seed, input int flip,
                          input logic [9:0] exp_info, input logic exp_ok);
        logic [7:0] h;
        logic       b;
        int         v0;
        h = hec_ref(info, seed);
        for (int j = 0; j < 18; j++) begin
            b = (j < 10) ? info[j] : h[17-j];
            for (int r = 0; r < 3; r++) begin
                rx_samp[3*j+r] = b;
                if (flip == 1 && r == j % 3) rx_samp[3*j+r] = ~b;
                if (flip == 2 && j == 3 && r < 2) rx_samp[3*j+r] = ~b;
            end
        end
        mode_br = 1'b1; mode_id = 1'b0; hec_init = seed;
        rx_q.push_back('{info: exp_info, ok: exp_ok});
        last_info = exp_info; last_ok = exp_ok;
        v0 = valid_cnt;
        clr_mon();
        rx_sync_hit = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 4; i++) tick(1'($urandom_range(0, 1)));
        for (int i = 0; i < 54; i++) tick(rx_samp[i]);
        for (int i = 0; i < 4; i++) tick(1'b0);
        check_eq("rx_valid_pulses", 32'(valid_cnt - v0), 32'd1);
        check_eq("rx_py_at", 32'(py_at), 32'd58);
        check_eq("rx_hdr_ticks", 32'(hdr_ticks), 32'd54);
        check_eq("rx_txbit_quiet", 32'(txbit), 32'd0);
    endtask

    logic [9:0]  info_a;
    logic [63:0] sw_a;
    int          v_abort;

    initial begin
        info_a = 10'(LT_ADDR_W'(5) << LT_ADDR_LSB) | 10'(TYPE_W'(4) << TYPE_LSB)
               | 10'(1 << FLOW_IDX) | 10'(0 << ARQN_IDX) | 10'(1 << SEQN_IDX);
        sw_a = 64'hA5F0_3C96_1234_5678;
        repeat (3) @(posedge clk_6M);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk_6M);
        #1;
        check_eq("rst_txbit", 32'(txbit), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_hdr_en", 32'(hdr_en), 32'd0);
        check_eq("rst_strobes", 32'({guard_st_p, edrsync_st_p, py_st_p, pkt_done_p}), 32'd0);
        check_eq("rst_rx_info", 32'(rx_hdr_info), 32'd0);
        check_eq("rst_valid_ok", 32'({rx_hdr_valid, hec_ok}), 32'd0);
`ifdef HDR_SEQ_HECCNT_EN
        check_eq("rst_hec_err_cnt", 32'(hec_err_cnt), 32'd0);
`endif

        run_tx(sw_a, 10'h000, 8'h00, 1'b1, 1'b0, 130, 126, 0, 0);
        run_tx(sw_a, 10'h000, 8'h00, 1'b0, 1'b0, 146, 142, 126, 131);

        run_rx(info_a, 8'h47, 0, info_a, 1'b1);
        run_rx(info_a, 8'h47, 1, info_a, 1'b1);
        run_rx(info_a, 8'h47, 2, info_a ^ 10'h008, 1'b0);
`ifdef HDR_SEQ_HECCNT_EN
        check_eq("hec_err_cnt", 32'(hec_err_cnt), 32'd1);
`endif

        // TX with a non-trivial header; hec_ok must keep the last RX result.
        run_tx(~sw_a, info_a, 8'h47, 1'b1, 1'b0, 130, 126, 0, 0);
        check_eq("tx_keeps_hec_ok", 32'(hec_ok), 32'(last_ok));

        run_tx(sw_a, 10'h3FF, 8'hFF, 1'b1, 1'b1, 72, 68, 0, 0);

        // Abort during HDR tick 20 of an RX header.
        v_abort = valid_cnt;
        mode_br = 1'b1; mode_id = 1'b0;
        clr_mon();
        rx_sync_hit = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 4 + 19; i++) tick(1'($urandom_range(0, 1)));
        abort = 1'b1;
        tick(1'b1);
        check_eq("abort_busy", 32'(busy_post), 32'd0);
        for (int i = 0; i < 10; i++) tick(1'b0);
        check_eq("abort_no_valid", 32'(valid_cnt - v_abort), 32'd0);
        check_eq("abort_no_py", 32'(py_cnt + pkt_cnt + guard_cnt), 32'd0);
        check_eq("abort_rx_info", 32'(rx_hdr_info), 32'(last_info));

        // tx_start and rx_sync_hit together: TX wins.
        mode_br = 1'b1; mode_id = 1'b0; syncword = sw_a;
        build_tx(sw_a, 10'h000, 8'h00, 1'b0);
        clr_mon();
        chk_tx = 1'b1;
        tx_start = 1'b1; rx_sync_hit = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 7; i++) tick(1'b0);
        chk_tx = 1'b0;
        check_eq("both_busy", 32'(busy), 32'd1);
        check_eq("both_no_hdr", 32'(hdr_ticks), 32'd0);
        abort = 1'b1;
        tick(1'b0);
        check_eq("both_abort_busy", 32'(busy_post), 32'd0);
        check_eq("scoreboard_drained", 32'(rx_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hdr_seq_p.md
Name: hdr_seq_p

Overview:
- Parametrised successor to the packet-header bit sequencer; one engine for both TX and RX.
- TX: emits access code and FEC1/3-encoded header with internally generated HEC.
- RX: majority-vote decodes header, checks HEC, captures fields.
- Sits between the access-code correlator/modulator and the payload engine. Timing strobes are on the p_1us bit tick.

Parameters:
- SYNC_BITS, 64, sync word length; MSB transmitted first.
- PRE_BITS, 4, preamble length.
- TRL_BITS, 4, trailer length.
- FEC_REP, 3, header repetition factor; odd, range 1..5.
- GUARD_BITS, 5, EDR guard length.
- EDRSYNC_BITS, 11, EDR sync length.

Ports:
- clk_6M  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- p_1us  in  1  one-cycle bit-tick strobe.
- tx_start  in  1  start TX packet; sampled on p_1us while IDLE.
- rx_sync_hit  in  1  correlator sync-end pulse; sampled on p_1us while IDLE.
- abort  in  1  return to IDLE.
- mode_id  in  1  ID packet: access code only.
- mode_br  in  1  1 = BR, 0 = EDR.
- syncword  in  SYNC_BITS  access code sync word.
- hec_init  in  8  HEC LFSR seed (UAP).
- tx_hdr_info  in  10  {SEQN, ARQN, FLOW, TYPE[3:0], LT_ADDR[2:0]}.
- rxbit  in  1  demodulated bit, valid on p_1us.
- txbit  out  1  TX bit stream.
- busy  out  1  not IDLE.
- hdr_en  out  1  in HEADER state (whitening enable).
- guard_st_p, edrsync_st_p, py_st_p, pkt_done_p  out  1 each  one-cycle strobes.
- rx_hdr_info  out  10  decoded header fields.
- rx_hdr_valid  out  1  pulse: header decoded and HEC checked.
- hec_ok  out  1  result of the last HEC check.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, rx_hdr_info 0.
- FSM states: IDLE, PRE, SYNC, TRL, HDR, GUARD, EDRS. All transitions occur on p_1us, except abort.
- abort returns to IDLE on the next clk_6M edge, from any state. No strobes fire on abort.
- bitcnt resets to 0 on every state entry.
- TX entry: IDLE→PRE.
- RX entry: IDLE→TRL.
- tx_start and rx_sync_hit on the same tick: TX wins. Starts while busy are ignored.
- PRE (PRE_BITS ticks): txbit = syncword[MSB] ^ bitcnt[0].
- SYNC (SYNC_BITS ticks): txbit = syncword[SYNC_BITS-1-bitcnt].
  - mode_id: at SYNC end, pkt_done_p fires and the FSM returns to IDLE.
- TRL (TRL_BITS ticks): txbit = ~syncword[0] ^ bitcnt[0].
- HDR: 18 × FEC_REP ticks. Header bit index k = bitcnt / FEC_REP; a rep counter avoids division.
  - k 0..9: tx_hdr_info[k], LSB first.
  - k 10..17: hec[7-(k-10)], MSB first.
  - Each bit is repeated FEC_REP times.
- HEC generator: 8-bit LFSR, polynomial 0x1A7.
  - Seeded with hec_init on HDR entry.
  - Per info bit b: fb = r[7]^b; r = {r[6:0],0} ^ (fb ? 8'hA7 : 0).
  - The LFSR is frozen during bits 10..17.
- RX decode: per header bit, count the FEC_REP rxbit samples; decoded = count > FEC_REP/2.
  - Bits 0..9 shift into rx_hdr_info LSB-first and clock the same LFSR.
  - Bits 10..17 are compared MSB-first against the LFSR.
- At HDR end:
  - RX: hec_ok = all 8 compared bits equal. rx_hdr_valid pulses one cycle later, together with the hec_ok update.
  - TX: hec_ok is unchanged.
- After HDR:
  - BR: py_st_p fires, then IDLE.
  - EDR: guard_st_p fires, GUARD for GUARD_BITS ticks; edrsync_st_p fires, EDRS for EDRSYNC_BITS ticks; then py_st_p fires, then IDLE.
- pkt_done_p fires coincident with every py_st_p, and at ID end.
- txbit is 0 outside PRE/SYNC/TRL/HDR and in all RX states.
- txbit is registered, changing on the p_1us cycle. Latency from tick to bit: 1 clk_6M.
- If the FEC_REP counter has not wrapped, no partial bit is emitted. abort discards the partial header; rx_hdr_info keeps its last valid value.

Optional Feature:
- Macro HDR_SEQ_HECCNT_EN adds output hec_err_cnt[15:0].
  - Increments on each rx_hdr_valid with hec_ok=0.
  - Saturates at 16'hFFFF; cleared by rst.
- Without the macro: no port and no counter.

Decomposition:
- Package hdr_seq_pkg holds:
  - state enum;
  - HEC_POLY = 8'hA7;
  - HDR_INFO_W = 10, HEC_W = 8;
  - field index constants for LT_ADDR, TYPE, FLOW, ARQN, SEQN.
- One sub-module, hdr_hec_lfsr: seed load, step enable, data bit, 8-bit state out.

Test Plan:
- TX BR, syncword MSB=1, tx_hdr_info=0, hec_init=0:
  - txbit 1,0,1,0 preamble;
  - then sync bits;
  - then 54 header ticks all 0 (HEC=0);
  - py_st_p at tick 4+64+4+54=126.
- TX EDR, same setup: guard_st_p at tick 126, edrsync_st_p at tick 131, py_st_p at tick 142.
- RX loopback of a TX stream with info=10'h2A5, hec_init=8'h47: rx_hdr_info=10'h2A5, hec_ok=1, one rx_hdr_valid pulse.
- RX same stream, one sample of each triple flipped: decoded info still 10'h2A5, hec_ok=1. Two samples of bit 3 flipped: hec_ok=0.
- mode_id TX: pkt_done_p after 68 ticks; no HDR state; hdr_en never high.
- abort asserted in HDR tick 20: IDLE next clk_6M; no rx_hdr_valid; rx_hdr_info unchanged. tx_start and rx_sync_hit on the same tick: PRE entered.
